// File: rtl/prog_loader_pkg.sv
// Shared widths, word-packing constants and loader state encoding for prog_loader.
package prog_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DEFAULT_DATA_W = 18;
  localparam int unsigned BYTES_PER_WORD = 3;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    FINISH,
    CHECK
  } state_e;

endpackage

// File: rtl/prog_word_packer.sv
// Packs three MSB-first stream bytes into one instruction word; only byte0[1:0] survives.
module prog_word_packer
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        din,
  output logic              last_c,
  output logic [DATA_W-1:0] word,
  output logic              word_ready
);

  localparam int unsigned SR_W = DATA_W - 8;

  logic [1:0]      idx;
  logic [SR_W-1:0] sr;

  // The byte being offered completes a word.
  assign last_c = (idx == 2'(BYTES_PER_WORD - 1));

  // Shift keeps only the low SR_W bits, so the unused top of byte0 falls away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sr         <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        idx <= '0;
        sr  <= '0;
      end else if (take) begin
        if (last_c) begin
          idx        <= '0;
          word       <= {sr, din};
          word_ready <= 1'b1;
        end else begin
          idx <= idx + 2'd1;
          sr  <= SR_W'({sr, din});
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program-memory boot loader: holds the MCU in reset and writes packed words from a byte stream.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W:0]   LEN,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [ADDR_W-1:0] PROG_ADDR,
  output logic              WR_EN,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(1) << ADDR_W;

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] addr_q;
  logic [ADDR_W:0] addr_inc;
  logic [TO_W-1:0] tcnt_q;
  logic            start_ok;
  logic            ld_clear;
  logic            take;
  logic            pk_take;
  logic            last_byte;
  logic            timeout;
  logic            err_d;
  logic            hold_d;

  // Counter is one bit wider than the address so LEN=1024 compares before any wrap.
  assign start_ok = START && (LEN != '0) && (LEN <= MAX_LEN);
  assign ld_clear = (state_q == IDLE) && start_ok;
  assign take     = RX_VALID && RX_READY;
  assign pk_take  = take && (state_q == RECV);
  assign addr_inc = addr_q + (ADDR_W + 1)'(1);
  assign timeout  = (tcnt_q == TO_W'(TIMEOUT_CYC - 1));

  assign PROG_ADDR = BUSY ? addr_q[ADDR_W-1:0] : CPU_ADDR;

  prog_word_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (ld_clear),
    .take       (pk_take),
    .din        (RX_DATA),
    .last_c     (last_byte),
    .word       (WR_DATA),
    .word_ready (WR_EN)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every data byte accepted in this load.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      csum_q <= '0;
    end else if (ld_clear) begin
      csum_q <= '0;
    end else if (pk_take) begin
      csum_q <= csum_q ^ RX_DATA;
    end
  end
`endif

  // Next-state logic; ERR and CPU_HOLD are sticky and only move on explicit events.
  always_comb begin
    state_d = state_q;
    err_d   = ERR;
    hold_d  = CPU_HOLD;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RECV;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      RECV: begin
        if (take) begin
          if (last_byte) state_d = WRITE;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WRITE: begin
        if (addr_inc != len_q) begin
          state_d = RECV;
        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = FINISH;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (take) begin
          if (RX_DATA == csum_q) begin
            state_d = FINISH;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
`endif
      FINISH: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      RX_READY <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      CPU_HOLD <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      RX_READY <= (state_d == RECV) || (state_d == CHECK);
      BUSY     <= (state_d == RECV) || (state_d == WRITE) || (state_d == CHECK);
      DONE     <= (state_d == FINISH);
      ERR      <= err_d;
      CPU_HOLD <= hold_d;
      if (ld_clear) begin
        len_q  <= LEN;
        addr_q <= '0;
      end else if (state_q == WRITE) begin
        addr_q <= addr_inc;
      end
      // Idle-gap counter only runs while waiting on the stream.
      if (take || !RX_READY) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes are queued as bytes are sent and popped on WR_EN.
module tb_prog_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 18;
  localparam int unsigned TO = 100;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] cpu_addr;
  logic [AW-1:0] prog_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            errors   = 0;
  int            checks   = 0;
  int            n_writes = 0;
  int            n0;
  logic [AW-1:0] addr_model;
  logic [7:0]    csum;
  logic [DW-1:0] d;

  prog_loader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .START     (start),
    .LEN       (len),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .RX_READY  (rx_ready),
    .CPU_ADDR  (cpu_addr),
    .PROG_ADDR (prog_addr),
    .WR_EN     (wr_en),
    .WR_DATA   (wr_data),
    .CPU_HOLD  (cpu_hold),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    csum     = csum ^ b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check1("rx_ready_wait", rx_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    wr_t e;
    e.addr = addr_model;
    e.data = {b0[1:0], b1, b2};
    exp_q.push_back(e);
    addr_model = addr_model + 10'd1;
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic pulse_start(input logic [AW:0] n);
    @(negedge clk);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_load(input logic [AW:0] n);
    addr_model = '0;
    csum       = '0;
    pulse_start(n);
  endtask

  task automatic end_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    rx_valid = 1'b0;
  endtask

  task automatic finish_ok(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_done"}, done, 1'b1);
    check1({tag, "_busy_fin"}, busy, 1'b0);
    check1({tag, "_hold_fin"}, cpu_hold, 1'b1);
    check1({tag, "_err_fin"}, err, 1'b0);
    @(negedge clk);
    check1({tag, "_done_pulse"}, done, 1'b0);
    check1({tag, "_hold_rel"}, cpu_hold, 1'b0);
  endtask

  // Scoreboard: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_writes++;
      check1("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkw("wr_addr", 32'(prog_addr), 32'(mon_e.addr));
        checkw("wr_data", 32'(wr_data), 32'(mon_e.data));
        check1("wr_hold", cpu_hold, 1'b1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    cpu_addr   = '0;
    addr_model = '0;
    csum       = '0;
    d          = '0;
    repeat (3) @(negedge clk);
    check1("rst_rx_ready", rx_ready, 1'b0);
    check1("rst_wr_en", wr_en, 1'b0);
    check1("rst_hold", cpu_hold, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    checkw("rst_wr_data", 32'(wr_data), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU address passes straight through while idle
    cpu_addr = 10'h155;
    #1;
    checkw("pass_prog_addr", 32'(prog_addr), 32'h155);
    @(negedge clk);

    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    @(negedge clk);
    check1("idle_rx_ready", rx_ready, 1'b0);
    rx_valid = 1'b0;

    // Two-word load with RX_VALID held across bytes
    begin_load(11'd2);
    check1("len2_busy", busy, 1'b1);
    check1("len2_hold", cpu_hold, 1'b1);
    checkw("len2_prog_addr", 32'(prog_addr), 32'h0);
    send_word(8'h03, 8'hFF, 8'h01);
    send_word(8'h00, 8'h12, 8'h34);
    end_load();
    finish_ok("len2");
    checkw("len2_drained", 32'(exp_q.size()), 32'h0);

    // Out-of-range lengths are ignored
    pulse_start(11'd0);
    repeat (3) @(negedge clk);
    check1("len0_busy", busy, 1'b0);
    check1("len0_hold", cpu_hold, 1'b0);
    pulse_start(11'd1500);
    repeat (3) @(negedge clk);
    check1("len1500_busy", busy, 1'b0);

    // START while busy must not restart the load
    begin_load(11'd1);
    pulse_start(11'd5);
    send_word(8'hFE, 8'hA5, 8'h5A);
    end_load();
    finish_ok("busy_start");

    // Stream stalls mid-word: timeout after TO idle cycles
    begin_load(11'd3);
    send_word(8'h11, 8'h22, 8'h33);
    send_byte(8'h44);
    rx_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check1("to_err_early", err, 1'b0);
    check1("to_busy_early", busy, 1'b1);
    @(negedge clk);
    check1("to_err", err, 1'b1);
    check1("to_busy", busy, 1'b0);
    check1("to_hold", cpu_hold, 1'b1);
    repeat (3) @(negedge clk);
    check1("to_err_sticky", err, 1'b1);
    check1("to_hold_sticky", cpu_hold, 1'b1);
    begin_load(11'd1);
    check1("rec_err_clr", err, 1'b0);
    send_word(8'h2A, 8'hBC, 8'hDE);
    end_load();
    finish_ok("recover");

    // Reset mid-load releases the MCU
    begin_load(11'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check1("mid_rst_hold", cpu_hold, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_ready", rx_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 1024-word image; garbage in byte0[7:2] must be dropped
    n0 = n_writes;
    begin_load(11'd1024);
    for (int i = 0; i < 1024; i++) begin
      d = DW'(i * 37) ^ 18'h2A5A5;
      send_word({6'h2B, d[17:16]}, d[15:8], d[7:0]);
    end
    end_load();
    finish_ok("len1024");
    checkw("len1024_count", 32'(n_writes - n0), 32'd1024);
    repeat (5) @(negedge clk);
    checkw("len1024_drained", 32'(exp_q.size()), 32'h0);

`ifdef PROG_LOADER_CHECKSUM_EN
    begin_load(11'd1);
    send_word(8'h01, 8'h02, 8'h03);
    send_byte(8'h00);
    rx_valid = 1'b0;
    finish_ok("csum_ok");
    begin_load(11'd1);
    send_word(8'h01, 8'h02, 8'h03);
    send_byte(8'h05);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check1("csum_bad_err", err, 1'b1);
    check1("csum_bad_hold", cpu_hold, 1'b1);
    check1("csum_bad_busy", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot/reload controller for the RAT MCU's 1024x18 program memory.
- Receives a byte stream (e.g. from the UART receiver), packs each 3 bytes into an 18-bit instruction and writes it sequentially into program memory.
- While loading, it holds the MCU in reset and owns the memory address port. Otherwise it passes the CPU fetch address through.

Parameters:
- ADDR_W, 10, program memory address width (1024 words)
- DATA_W, 18, instruction width
- TIMEOUT_CYC, 50_000_000, max idle cycles between bytes during a load (1 s at 50 MHz)

Ports:
- CLK  in  1  system clock (same clock as PROG_CLK of program memory)
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse; begins a load
- LEN  in  ADDR_W+1  word count, sampled on START; valid range 1..1024
- RX_DATA  in  8  stream byte
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  loader accepts byte this cycle
- CPU_ADDR  in  ADDR_W  MCU program counter
- PROG_ADDR  out  ADDR_W  address to program memory
- WR_EN  out  1  program memory write strobe
- WR_DATA  out  DATA_W  word to write
- CPU_HOLD  out  1  drives MCU reset
- BUSY  out  1  load in progress
- DONE  out  1  one-cycle pulse on successful completion
- ERR  out  1  sticky load error

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - state=IDLE; RX_READY, WR_EN, CPU_HOLD, BUSY, DONE and ERR are all 0
  - WR_DATA=0; address counter=0
- Clock and reset: one clock CLK; reset RESET_N is asynchronous, active-low.
- PROG_ADDR is combinational:
  - when BUSY=0: PROG_ADDR = CPU_ADDR
  - otherwise: PROG_ADDR = loader address
- Program memory read latency (1 cycle) is unchanged.
- States: IDLE, RECV, WRITE, FINISH.
- IDLE:
  - START=1 with LEN in 1..1024: latch LEN, clear address, byte index and ERR; set BUSY=1 and CPU_HOLD=1; go to RECV.
  - START with LEN=0 or LEN>1024: ignored.
- RECV:
  - RX_READY=1. A byte is taken when RX_VALID&RX_READY.
  - Byte order is MSB first:
    - byte0[1:0] -> word[17:16] (byte0[7:2] ignored)
    - byte1 -> word[15:8]
    - byte2 -> word[7:0]
  - After byte2 is taken, go to WRITE.
- WRITE (exactly 1 cycle):
  - WR_EN=1, WR_DATA=packed word, PROG_ADDR=current address; RX_READY=0.
  - Next cycle: address+1. If address+1==LEN go to FINISH, else go to RECV.
- FINISH (1 cycle):
  - DONE=1 and BUSY=0; CPU_HOLD drops on the following cycle; return to IDLE.
- Timeout: a counter resets on each accepted byte and counts in RECV. On reaching TIMEOUT_CYC:
  - ERR=1, BUSY=0, go to IDLE
  - CPU_HOLD stays 1 so a partial program never runs
- ERR and CPU_HOLD=1 persist until a subsequent successful load or reset.
- START while BUSY: ignored.
- RX_VALID outside RECV: not accepted, and the byte is not lost by the loader (RX_READY=0).
- Last word at address 1023 with LEN=1024: the address counter must not wrap before the compare. The counter is ADDR_W+1 bits wide; PROG_ADDR uses the low ADDR_W bits.
- Reset mid-load: immediate return to reset values. CPU_HOLD releases; memory contents written so far are retained.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter state CHECK and accept one extra byte.
  - It must equal the XOR of all data bytes received in this load.
  - Match: go to FINISH.
  - Mismatch: ERR=1, CPU_HOLD stays 1, return to IDLE.
  - The timeout also applies in CHECK.
- Undefined: no CHECK state and no checksum logic; the transition from WRITE goes directly to FINISH.

Decomposition:
- Package prog_loader_pkg holds:
  - ADDR_W and DATA_W defaults
  - BYTES_PER_WORD=3
  - state enum typedef (IDLE, RECV, WRITE, FINISH, CHECK)
- One natural sub-module, prog_word_packer:
  - 2-bit byte index plus shift register
  - outputs the packed 18-bit word and a word_ready flag
  - cleared on START

Test Plan:
- LEN=2, bytes 03 FF 01, 00 12 34 (RX_VALID held high) -> WR_EN pulses at addr 0 data 0x3FF01, then addr 1 data 0x01234; DONE one cycle; CPU_HOLD=1 throughout, 0 the cycle after DONE.
- BUSY=0, CPU_ADDR=0x155 -> PROG_ADDR=0x155 same cycle. START -> PROG_ADDR follows loader address.
- LEN=1024, streaming bytes -> 1024 writes; last at addr 0x3FF; DONE; no write to address 0 after 0x3FF.
- LEN=3, stream stops after 4 bytes, TIMEOUT_CYC=100 -> ERR=1 at cycle 100 after the last byte, CPU_HOLD stays 1. New START with LEN=1 and a good word -> ERR=0, DONE, CPU_HOLD=0.
- START with LEN=0, and START while BUSY -> no state change, no extra write.
- With PROG_LOADER_CHECKSUM_EN: LEN=1, bytes 01 02 03 then checksum 00 -> DONE; with checksum 05 -> ERR=1, CPU_HOLD=1.
